// File: rtl/lsu_mem_adapter.sv
// Load/store adapter: turns byte..dword requests into aligned 64-bit memory
// accesses with a bytemask, then aligns and extends read data into a one-cycle response.
module lsu_mem_adapter #(
  parameter int DMEM_ADDRESS_WIDTH = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [1:0]                    req_size,
  input  logic                          req_signed,
  input  logic [DMEM_ADDRESS_WIDTH-1:0] req_addr,
  input  logic [63:0]                   req_wdata,
  output logic                          resp_valid,
  output logic                          resp_err,
  output logic [63:0]                   resp_rdata,
  output logic [15:0]                   last_latency,
  output logic [DMEM_ADDRESS_WIDTH-1:0] mem_address,
  output logic [63:0]                   mem_data_in,
  output logic [7:0]                    mem_bytemask,
  output logic                          mem_write,
  output logic                          mem_start_access,
  input  logic                          mem_access_done,
  input  logic [63:0]                   mem_data_out
);
  localparam int AW = DMEM_ADDRESS_WIDTH;
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          wr_q, wr_d, sgn_q, sgn_d, err_q, err_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0]   cnt_q, cnt_d, lat_q, lat_d;

  logic          misaligned, busy;
  logic [5:0]    sh;
  logic [15:0]   cnt_inc;
  logic [63:0]   ld_shift, ld_data;
  logic [7:0]    base_mask;

  always_comb begin
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign sh      = {addr_q[2:0], 3'b000};
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Extract the addressed field from the aligned dword, then extend it.
  assign ld_shift = mem_data_out >> sh;
  always_comb begin
    case (size_q)
      2'd0:    ld_data = {{56{sgn_q & ld_shift[7]}},  ld_shift[7:0]};
      2'd1:    ld_data = {{48{sgn_q & ld_shift[15]}}, ld_shift[15:0]};
      2'd2:    ld_data = {{32{sgn_q & ld_shift[31]}}, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = misaligned;
          cnt_d   = '0;
          state_d = misaligned ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_inc;
        if (mem_access_done) begin
          // Count includes the done cycle itself.
          lat_d   = cnt_inc;
          rdata_d = wr_q ? '0 : ld_data;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  // Memory command is a pure function of latched state, so it holds for all of BUSY.
  assign busy             = (state_q == S_BUSY);
  assign mem_start_access = busy;
  assign mem_address      = busy ? {addr_q[AW-1:3], 3'b000} : '0;
  assign mem_data_in      = busy ? (wdata_q << sh) : '0;
  assign mem_bytemask     = busy ? (wr_q ? (base_mask << addr_q[2:0]) : 8'hFF) : 8'h00;
  assign mem_write        = busy & wr_q;

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP);
  assign resp_err     = resp_valid & err_q;
  assign resp_rdata   = resp_valid ? rdata_q : '0;
  assign last_latency = lat_q;
endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed bench for lsu_mem_adapter with a small behavioural data memory
// (slow on a new line, fast when the same line is hit again).
module tb_lsu_mem_adapter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [19:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic [15:0] last_latency;
  logic [19:0] mem_address;
  logic [63:0] mem_data_in, mem_data_out;
  logic [7:0]  mem_bytemask;
  logic        mem_write, mem_start_access, mem_access_done;

  always #5 clk = ~clk;

  lsu_mem_adapter #(.DMEM_ADDRESS_WIDTH(20)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .last_latency(last_latency),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_bytemask(mem_bytemask), .mem_write(mem_write),
    .mem_start_access(mem_start_access), .mem_access_done(mem_access_done),
    .mem_data_out(mem_data_out)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural memory: 6 wait cycles on a new line, 2 on a repeated line.
  logic [63:0] mem [0:127];
  logic        inited = 1'b0, line_vld;
  logic [16:0] last_line;
  int          mcnt, cur_wait;
  assign cur_wait = (line_vld && last_line == mem_address[19:3]) ? 2 : 6;

  always @(posedge clk) begin
    if (reset) begin
      if (!inited) begin
        for (int i = 0; i < 128; i++) mem[i] <= 64'h0;
        mem[64] <= 64'hDEAD_BEEF_CAFE_F00D;
        inited  <= 1'b1;
      end
      mem_access_done <= 1'b0;
      mem_data_out    <= 64'h0;
      mcnt            <= 0;
      line_vld        <= 1'b0;
      last_line       <= '0;
    end else begin
      mem_access_done <= 1'b0;
      if (mem_start_access && !mem_access_done) begin
        if (mcnt + 1 >= cur_wait) begin
          mem_access_done <= 1'b1;
          mcnt            <= 0;
          line_vld        <= 1'b1;
          last_line       <= mem_address[19:3];
          mem_data_out    <= mem[mem_address[9:3]];
          if (mem_write)
            for (int k = 0; k < 8; k++)
              if (mem_bytemask[k]) mem[mem_address[9:3]][8*k +: 8] <= mem_data_in[8*k +: 8];
        end else mcnt <= mcnt + 1;
      end
    end
  end

  // Command stability and alignment while start_access is held.
  int          start_cnt = 0;
  logic        prev_start = 1'b0;
  logic [92:0] prev_bus;
  always @(negedge clk) begin
    if (mem_start_access) begin
      start_cnt++;
      chk("addr_lsb", 64'(mem_address[2:0]), 64'h0);
      if (prev_start)
        chk("mem_stable", 64'({mem_address, mem_data_in, mem_bytemask, mem_write} ^ prev_bus), 64'h0);
    end
    prev_start = mem_start_access;
    prev_bus   = {mem_address, mem_data_in, mem_bytemask, mem_write};
  end

  logic [63:0] r_rdata, cap_data;
  logic [19:0] cap_addr;
  logic [7:0]  cap_mask;
  logic [15:0] r_lat;
  logic        r_err, r_rdy, r_start, cap_wr, cap_rdy;
  int          r_n;

  task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [19:0] a, input logic [63:0] wd, input bit hold);
    bit got = 0, cap = 0;
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    start_cnt = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_start_access && !cap) begin
        cap = 1; cap_addr = mem_address; cap_mask = mem_bytemask;
        cap_data = mem_data_in; cap_wr = mem_write; cap_rdy = req_ready;
      end
      if (resp_valid) begin
        got = 1; r_rdata = resp_rdata; r_err = resp_err; r_lat = last_latency;
        r_rdy = req_ready; r_start = mem_start_access;
      end
    end
    r_n = n;
    chk("resp_seen", 64'(got), 64'h1);
  endtask

  task automatic expect_ok(input string tag, input logic [63:0] rd, input int b);
    chk({tag, ".err"},    64'(r_err),     64'h0);
    chk({tag, ".rdata"},  r_rdata,        rd);
    chk({tag, ".lat"},    64'(r_lat),     64'(b));
    chk({tag, ".ncyc"},   64'(r_n),       64'(b + 1));
    chk({tag, ".starts"}, 64'(start_cnt), 64'(b));
  endtask

  task automatic expect_err(input string tag, input int prev_lat);
    chk({tag, ".err"},    64'(r_err),     64'h1);
    chk({tag, ".rdata"},  r_rdata,        64'h0);
    chk({tag, ".ncyc"},   64'(r_n),       64'h1);
    chk({tag, ".starts"}, 64'(start_cnt), 64'h0);
    chk({tag, ".lat"},    64'(r_lat),     64'(prev_lat));
  endtask

  initial begin
    bit saw_resp;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready",  64'(req_ready),    64'h1);
    chk("rst.rvalid", 64'(resp_valid),   64'h0);
    chk("rst.rerr",   64'(resp_err),     64'h0);
    chk("rst.rdata",  resp_rdata,        64'h0);
    chk("rst.lat",    64'(last_latency), 64'h0);
    chk("rst.mem",    64'({mem_start_access, mem_write, mem_bytemask, mem_address}), 64'h0);
    chk("rst.din",    mem_data_in,       64'h0);
    reset = 1'b0;

    txn(1, 3, 0, 20'h100, 64'h0123_4567_89AB_CDEF, 0);
    expect_ok("st_d", 64'h0, 7);
    chk("st_d.mask", 64'(cap_mask), 64'hFF);
    chk("st_d.din",  cap_data,      64'h0123_4567_89AB_CDEF);
    chk("st_d.wr",   64'(cap_wr),   64'h1);

    txn(0, 3, 0, 20'h100, 64'h0, 0);
    expect_ok("ld_d", 64'h0123_4567_89AB_CDEF, 3);
    chk("ld_d.mask", 64'(cap_mask), 64'hFF);
    chk("ld_d.wr",   64'(cap_wr),   64'h0);

    txn(1, 0, 0, 20'h103, 64'h80, 0);
    expect_ok("st_b", 64'h0, 3);
    chk("st_b.addr", 64'(cap_addr), 64'h100);
    chk("st_b.mask", 64'(cap_mask), 64'h08);
    chk("st_b.din",  cap_data,      64'h0000_0000_8000_0000);

    txn(0, 0, 1, 20'h103, 64'h0, 0);
    expect_ok("ld_bs", 64'hFFFF_FFFF_FFFF_FF80, 3);
    txn(0, 0, 0, 20'h103, 64'h0, 0);
    expect_ok("ld_bu", 64'h80, 3);

    txn(1, 1, 0, 20'h106, 64'h8001, 0);
    expect_ok("st_h", 64'h0, 3);
    chk("st_h.mask", 64'(cap_mask), 64'hC0);
    chk("st_h.din",  cap_data,      64'h8001_0000_0000_0000);

    txn(0, 1, 1, 20'h106, 64'h0, 0);
    expect_ok("ld_hs", 64'hFFFF_FFFF_FFFF_8001, 3);
    txn(0, 2, 0, 20'h104, 64'h0, 0);
    expect_ok("ld_wu", 64'h0000_0000_8001_4567, 3);
    txn(0, 2, 1, 20'h104, 64'h0, 0);
    expect_ok("ld_ws", 64'hFFFF_FFFF_8001_4567, 3);

    txn(0, 2, 0, 20'h102, 64'h0, 0);
    expect_err("mis_w", 3);
    txn(1, 1, 0, 20'h101, 64'h1234, 0);
    expect_err("mis_h", 3);

    // Valid held high across both requests: new line misses, repeat hits.
    txn(0, 3, 0, 20'h200, 64'h0, 1);
    expect_ok("b2b1", 64'hDEAD_BEEF_CAFE_F00D, 7);
    chk("b2b1.rdy_busy", 64'(cap_rdy), 64'h0);
    chk("b2b1.rdy_resp", 64'(r_rdy),   64'h0);
    chk("b2b1.st_resp",  64'(r_start), 64'h0);
    txn(0, 3, 0, 20'h200, 64'h0, 1);
    req_valid = 1'b0;
    expect_ok("b2b2", 64'hDEAD_BEEF_CAFE_F00D, 3);

    // Reset two cycles into BUSY.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_addr = 20'h300;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort.busy1", 64'(mem_start_access), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.ready", 64'(req_ready),        64'h1);
    chk("abort.start", 64'(mem_start_access), 64'h0);
    chk("abort.addr",  64'(mem_address),      64'h0);
    chk("abort.lat",   64'(last_latency),     64'h0);
    saw_resp = resp_valid;
    repeat (10) begin
      @(negedge clk);
      saw_resp |= resp_valid;
    end
    chk("abort.noresp", 64'(saw_resp), 64'h0);

    txn(0, 3, 0, 20'h200, 64'h0, 0);
    expect_ok("post_rst", 64'hDEAD_BEEF_CAFE_F00D, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
